// File: rtl/burst_reorder_buffer.sv
// rtl/burst_reorder_buffer.sv - burst collector that replays a burst in LIFO or FIFO order
module burst_reorder_buffer #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter bit REVERSE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       busy,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          Din,
    output logic                       i_ready,
    output logic [DATA_W-1:0]          Dout,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {S_LOAD = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [DATA_W-1:0]   r_dout;
    logic                r_o_valid;
    logic                r_ovf;
    logic                w_accept;
    logic                w_empty;
    logic [AW-1:0]       w_rd_idx;

    assign w_empty  = (r_count == '0);
    assign w_accept = i_valid && i_ready;
    // In LIFO mode r_wr_ptr is the stack pointer; it wraps to 0 only when the
    // stack is exactly full, so sp-1 still addresses the top entry.
    assign w_rd_idx = REVERSE ? (r_wr_ptr - AW'(1)) : r_rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (!i_valid && !w_empty && !busy) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        i_ready = (r_state == S_LOAD) && (r_count < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= Din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dout    <= '0;
            r_o_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_dout    <= '0;
            r_o_valid <= 1'b0;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count  <= r_count + CW'(1);
            end else if (i_valid) begin
                r_ovf <= 1'b1;
            end
        end else begin
            if (w_empty) begin
                r_dout    <= '0;
                r_o_valid <= 1'b0;
                r_ovf     <= 1'b0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (i_valid) r_ovf <= 1'b1;
                if (busy) begin
                    r_dout    <= '0;
                    r_o_valid <= 1'b0;
                end else begin
                    r_dout    <= r_mem[w_rd_idx];
                    r_o_valid <= 1'b1;
                    r_count   <= r_count - CW'(1);
                    if (REVERSE) r_wr_ptr <= r_wr_ptr - AW'(1);
                    else         r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    assign Dout    = r_dout;
    assign o_valid = r_o_valid;
    assign count   = r_count;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_burst_reorder_buffer.sv
// tb/tb_burst_reorder_buffer.sv - directed bench driving a LIFO and a FIFO instance in lockstep
module tb_burst_reorder_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic       i_valid;
    logic [7:0] din;

    logic       l_ready, f_ready, l_valid, f_valid, l_ovf, f_ovf;
    logic [7:0] l_dout, f_dout;
    logic [4:0] l_count, f_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    burst_reorder_buffer #(.DATA_W(8), .DEPTH(16), .REVERSE(1'b1)) u_lifo (
        .clk(clk), .reset(reset), .busy(busy), .i_valid(i_valid), .Din(din),
        .i_ready(l_ready), .Dout(l_dout), .o_valid(l_valid), .count(l_count), .ovf(l_ovf)
    );

    burst_reorder_buffer #(.DATA_W(8), .DEPTH(16), .REVERSE(1'b0)) u_fifo (
        .clk(clk), .reset(reset), .busy(busy), .i_valid(i_valid), .Din(din),
        .i_ready(f_ready), .Dout(f_dout), .o_valid(f_valid), .count(f_count), .ovf(f_ovf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; busy = 1'b0; i_valid = 1'b0; din = 8'h00;
        repeat (3) cyc();
        n_checks++;
        if (l_valid !== 1'b0 || l_dout !== 8'h00 || l_count !== 5'd0 || l_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_lifo got v=%b d=%0d c=%0d o=%b exp 0/0/0/0", l_valid, l_dout, l_count, l_ovf);
        end
        n_checks++;
        if (f_valid !== 1'b0 || f_dout !== 8'h00 || f_count !== 5'd0 || f_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_fifo got v=%b d=%0d c=%0d o=%b exp 0/0/0/0", f_valid, f_dout, f_count, f_ovf);
        end
        reset = 1'b1;
        cyc();
        n_checks++;
        if (l_ready !== 1'b1 || f_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got l=%b f=%b exp 1", l_ready, f_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w [3];
        w[0] = 8'd11; w[1] = 8'd22; w[2] = 8'd33;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; din = w[k];
            #1;
            n_checks++;
            if (f_ready !== 1'b1 || l_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_ready[%0d] got l=%b f=%b exp 1", k, l_ready, f_ready);
            end
            cyc();
        end
        i_valid = 1'b0;
        cyc();
        n_checks++;
        if (l_valid !== 1'b0 || f_valid !== 1'b0 || l_count !== 5'd3) begin
            n_fail++; $display("FAIL basic_edge_n got lv=%b fv=%b c=%0d exp 0 0 3", l_valid, f_valid, l_count);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (l_valid !== 1'b1 || l_dout !== w[2-k]) begin
                n_fail++; $display("FAIL basic_lifo[%0d] got v=%b d=%0d exp 1 %0d", k, l_valid, l_dout, w[2-k]);
            end
            n_checks++;
            if (f_valid !== 1'b1 || f_dout !== w[k]) begin
                n_fail++; $display("FAIL basic_fifo[%0d] got v=%b d=%0d exp 1 %0d", k, f_valid, f_dout, w[k]);
            end
        end
        cyc();
        n_checks++;
        if (l_valid !== 1'b0 || l_count !== 5'd0 || f_valid !== 1'b0 || f_count !== 5'd0 || l_dout !== 8'h00) begin
            n_fail++; $display("FAIL basic_end got lv=%b lc=%0d fv=%b fc=%0d ld=%0d exp 0", l_valid, l_count, f_valid, f_count, l_dout);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 18; k++) begin
            i_valid = 1'b1; din = 8'(k);
            #1;
            n_checks++;
            if (l_ready !== (k <= 16) || f_ready !== (k <= 16)) begin
                n_fail++; $display("FAIL ovf_ready[%0d] got l=%b f=%b exp %b", k, l_ready, f_ready, (k <= 16));
            end
            cyc();
        end
        i_valid = 1'b0;
        n_checks++;
        if (l_ovf !== 1'b1 || f_ovf !== 1'b1 || l_count !== 5'd16 || f_count !== 5'd16) begin
            n_fail++; $display("FAIL ovf_full got lo=%b fo=%b lc=%0d fc=%0d exp 1 1 16 16", l_ovf, f_ovf, l_count, f_count);
        end
        cyc();
        for (int k = 0; k < 16; k++) begin
            cyc();
            n_checks++;
            if (l_valid !== 1'b1 || l_dout !== 8'(16 - k)) begin
                n_fail++; $display("FAIL ovf_lifo[%0d] got v=%b d=%0d exp 1 %0d", k, l_valid, l_dout, 16 - k);
            end
            n_checks++;
            if (f_valid !== 1'b1 || f_dout !== 8'(k + 1)) begin
                n_fail++; $display("FAIL ovf_fifo[%0d] got v=%b d=%0d exp 1 %0d", k, f_valid, f_dout, k + 1);
            end
        end
        cyc();
        n_checks++;
        if (l_ovf !== 1'b0 || f_ovf !== 1'b0 || l_valid !== 1'b0 || l_count !== 5'd0) begin
            n_fail++; $display("FAIL ovf_clear got lo=%b fo=%b lv=%b lc=%0d exp 0 0 0 0", l_ovf, f_ovf, l_valid, l_count);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_l, exp_f;
        for (int k = 1; k <= 5; k++) begin
            i_valid = 1'b1; din = 8'h40 + 8'(k);
            cyc();
        end
        i_valid = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                busy = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    cyc();
                    n_checks++;
                    if (l_valid !== 1'b0 || l_dout !== 8'h00 || f_valid !== 1'b0 || f_dout !== 8'h00 || l_count !== 5'd3) begin
                        n_fail++; $display("FAIL stall[%0d] got lv=%b ld=%0d fv=%b fd=%0d lc=%0d exp 0 0 0 0 3", s, l_valid, l_dout, f_valid, f_dout, l_count);
                    end
                end
                busy = 1'b0;
            end
            cyc();
            exp_l = 8'h45 - 8'(k);
            exp_f = 8'h41 + 8'(k);
            n_checks++;
            if (l_valid !== 1'b1 || l_dout !== exp_l || f_valid !== 1'b1 || f_dout !== exp_f) begin
                n_fail++; $display("FAIL stall_out[%0d] got lv=%b ld=%0h fv=%b fd=%0h exp 1 %0h 1 %0h", k, l_valid, l_dout, f_valid, f_dout, exp_l, exp_f);
            end
        end
        cyc();
        n_checks++;
        if (l_valid !== 1'b0 || l_count !== 5'd0 || f_count !== 5'd0) begin
            n_fail++; $display("FAIL stall_end got lv=%b lc=%0d fc=%0d exp 0 0 0", l_valid, l_count, f_count);
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] w [3];
        w[0] = 8'h71; w[1] = 8'h72; w[2] = 8'h73;
        busy = 1'b1;
        i_valid = 1'b1; din = w[0]; cyc();
        din = w[1]; cyc();
        i_valid = 1'b0; cyc();
        cyc();
        i_valid = 1'b1; din = w[2]; cyc();
        i_valid = 1'b0; cyc();
        n_checks++;
        if (l_valid !== 1'b0 || f_valid !== 1'b0 || l_count !== 5'd3 || l_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_load got lv=%b fv=%b lc=%0d lr=%b exp 0 0 3 1", l_valid, f_valid, l_count, l_ready);
        end
        busy = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (l_valid !== 1'b1 || l_dout !== w[2-k] || f_valid !== 1'b1 || f_dout !== w[k]) begin
                n_fail++; $display("FAIL hold_out[%0d] got lv=%b ld=%0h fv=%b fd=%0h exp 1 %0h 1 %0h", k, l_valid, l_dout, f_valid, f_dout, w[2-k], w[k]);
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1; din = 8'h90 + 8'(k); cyc();
        end
        i_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (l_valid !== 1'b1 || l_dout !== 8'h94) begin
            n_fail++; $display("FAIL rst_pre got v=%b d=%0h exp 1 94", l_valid, l_dout);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (l_valid !== 1'b0 || l_dout !== 8'h00 || l_count !== 5'd0 || f_valid !== 1'b0 || f_count !== 5'd0) begin
            n_fail++; $display("FAIL rst_async got lv=%b ld=%0h lc=%0d fv=%b fc=%0d exp 0", l_valid, l_dout, l_count, f_valid, f_count);
        end
        #2 reset = 1'b1;
        cyc();
        i_valid = 1'b1; din = 8'hA1; cyc();
        din = 8'hA2; cyc();
        i_valid = 1'b0; cyc();
        cyc();
        n_checks++;
        if (l_valid !== 1'b1 || l_dout !== 8'hA2 || f_valid !== 1'b1 || f_dout !== 8'hA1) begin
            n_fail++; $display("FAIL rst_after0 got lv=%b ld=%0h fv=%b fd=%0h exp 1 a2 1 a1", l_valid, l_dout, f_valid, f_dout);
        end
        cyc();
        n_checks++;
        if (l_valid !== 1'b1 || l_dout !== 8'hA1 || f_valid !== 1'b1 || f_dout !== 8'hA2) begin
            n_fail++; $display("FAIL rst_after1 got lv=%b ld=%0h fv=%b fd=%0h exp 1 a1 1 a2", l_valid, l_dout, f_valid, f_dout);
        end
        cyc();
        n_checks++;
        if (l_valid !== 1'b0 || l_count !== 5'd0 || l_ovf !== 1'b0) begin
            n_fail++; $display("FAIL rst_end got lv=%b lc=%0d lo=%b exp 0 0 0", l_valid, l_count, l_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        cyc();
        test_overflow();
        cyc();
        test_stall();
        cyc();
        test_busy_hold();
        cyc();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
